auto_parkcalc_two_streams_prod_scale_sat: RTL and testbench

- Downstream consumer of the 32s x 34ns -> 65-bit pipelined product in the parkcalc two-stream datapath.
- Takes the signed 65-bit fixed-point product and applies an arithmetic right shift by SHIFT with round-half-up.
- Saturates the result to OUT_WIDTH signed bits and emits it on a valid/ready stream.
- Two-stage stall-capable pipeline with bubble collapsing; also keeps a sticky saturation event counter for debug/status.

---
 rtl/auto_parkcalc_two_streams_prod_scale_sat.sv | 141 ++++++++++++++
 tb/tb_auto_parkcalc_two_streams_prod_scale_sat.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/auto_parkcalc_two_streams_prod_scale_sat.sv
// ---------------------------------------------------------------------------
// auto_parkcalc_two_streams_prod_scale_sat
//
// Scales the signed IN_WIDTH-bit product of the parkcalc two-stream datapath
// down by SHIFT fraction bits (round half toward +inf, or truncate toward
// -inf), saturates the result to OUT_WIDTH signed bits and hands it off on a
// valid/ready stream. Two register stages, stall-capable, with bubble
// collapsing so an empty output stage still pulls from stage 1 while the
// consumer is stalled. A sticky counter records how many clipped results
// were handed off.
//
// Ports:
//   ap_clk       clock, rising edge
//   ap_rst_n     synchronous active-low reset
//   prod_tdata   signed product in
//   prod_tvalid  product valid
//   prod_tready  stage 1 can accept (combinational from out_tready)
//   out_tdata    scaled, saturated result
//   out_tvalid   result valid
//   out_tready   downstream accepts
//   out_sat      result was clipped (qualified by out_tvalid)
//   sat_clear    synchronous clear of sat_count (wins over increment)
//   sat_count    clipped results handed off, sticks at all-ones
// ---------------------------------------------------------------------------
module auto_parkcalc_two_streams_prod_scale_sat #(
  parameter int IN_WIDTH  = 65,
  parameter int OUT_WIDTH = 32,
  parameter int SHIFT     = 32,
  parameter int ROUND     = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic signed [IN_WIDTH-1:0]  prod_tdata,
  input  logic                        prod_tvalid,
  output logic                        prod_tready,
  output logic signed [OUT_WIDTH-1:0] out_tdata,
  output logic                        out_tvalid,
  input  logic                        out_tready,
  output logic                        out_sat,
  input  logic                        sat_clear,
  output logic [CNT_WIDTH-1:0]        sat_count
);

  // One extra bit so adding the rounding bias can never overflow.
  localparam int SUM_W = IN_WIDTH + 1;

  // Clip limits, sign-extended to the pre-shift sum width.
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // Sign-extend the product and add half an output LSB when rounding.
  function automatic logic signed [SUM_W-1:0] round_bias(
    input logic signed [IN_WIDTH-1:0] p
  );
    logic signed [SUM_W-1:0] bias;
    bias = '0;
    if (ROUND != 0) bias[SHIFT-1] = 1'b1;
    return $signed({p[IN_WIDTH-1], p}) + bias;
  endfunction

  // Arithmetic shift then clip; returns {sat, data}.
  function automatic logic [OUT_WIDTH:0] scale_sat(
    input logic signed [SUM_W-1:0] sum
  );
    logic signed [SUM_W-1:0] sh;
    sh = sum >>> SHIFT;
    if (sh > SAT_MAX)
      return {1'b1, SAT_MAX[OUT_WIDTH-1:0]};
    else if (sh < SAT_MIN)
      return {1'b1, SAT_MIN[OUT_WIDTH-1:0]};
    return {1'b0, sh[OUT_WIDTH-1:0]};
  endfunction

  logic                        vld_p1;
  logic signed [SUM_W-1:0]     sum_p1;
  logic                        vld_p2;
  logic signed [OUT_WIDTH-1:0] data_p2;
  logic                        sat_p2;
  logic [CNT_WIDTH-1:0]        sat_cnt;

  logic                        adv1;
  logic                        adv2;
  logic                        in_xfer;
  logic                        out_xfer;
  logic [OUT_WIDTH:0]          res_p1;

  // A stage may load when it is empty or its contents move on this edge;
  // this is what lets an empty stage 2 swallow a bubble during a stall.
  assign adv2     = !vld_p2 || out_tready;
  assign adv1     = !vld_p1 || adv2;
  assign in_xfer  = prod_tvalid && adv1;
  assign out_xfer = vld_p2 && out_tready;
  assign res_p1   = scale_sat(sum_p1);

  assign prod_tready = adv1;
  assign out_tvalid  = vld_p2;
  assign out_tdata   = data_p2;
  assign out_sat     = sat_p2;
  assign sat_count   = sat_cnt;

  // ---- stage 1: sign-extend and apply rounding bias ----
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n)
      vld_p1 <= 1'b0;
    else if (adv1)
      vld_p1 <= prod_tvalid;
  end

  always_ff @(posedge ap_clk) begin
    if (in_xfer)
      sum_p1 <= round_bias(prod_tdata);
  end

  // ---- stage 2: shift, saturate, hold for the consumer ----
  // The output data register is reset too so out_tdata reads 0 after reset.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      sat_p2  <= 1'b0;
    end else if (adv2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        sat_p2  <= res_p1[OUT_WIDTH];
        data_p2 <= res_p1[OUT_WIDTH-1:0];
      end
    end
  end

  // ---- saturation event counter (counts handoffs, not stage loads) ----
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n || sat_clear)
      sat_cnt <= '0;
    else if (out_xfer && sat_p2 && (sat_cnt != '1))
      sat_cnt <= sat_cnt + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_auto_parkcalc_two_streams_prod_scale_sat.sv
module tb_auto_parkcalc_two_streams_prod_scale_sat;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [64:0] prod_tdata = '0;
  logic        prod_tvalid = 1'b0;
  logic        out_tready = 1'b0;
  logic        sat_clear = 1'b0;

  logic        m_tready, t_tready, c_tready;
  logic [31:0] m_data, t_data, c_data;
  logic        m_valid, t_valid, c_valid;
  logic        m_sat, t_sat, c_sat;
  logic [15:0] m_cnt, t_cnt;
  logic [3:0]  c_cnt;

  always #5 ap_clk = ~ap_clk;

  // Default build (round, 16-bit counter)
  auto_parkcalc_two_streams_prod_scale_sat u_main (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .prod_tdata(prod_tdata), .prod_tvalid(prod_tvalid), .prod_tready(m_tready),
    .out_tdata(m_data), .out_tvalid(m_valid), .out_tready(out_tready),
    .out_sat(m_sat), .sat_clear(sat_clear), .sat_count(m_cnt));

  // Truncating build
  auto_parkcalc_two_streams_prod_scale_sat #(.ROUND(0)) u_trunc (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .prod_tdata(prod_tdata), .prod_tvalid(prod_tvalid), .prod_tready(t_tready),
    .out_tdata(t_data), .out_tvalid(t_valid), .out_tready(out_tready),
    .out_sat(t_sat), .sat_clear(sat_clear), .sat_count(t_cnt));

  // Narrow-counter build
  auto_parkcalc_two_streams_prod_scale_sat #(.CNT_WIDTH(4)) u_cnt4 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .prod_tdata(prod_tdata), .prod_tvalid(prod_tvalid), .prod_tready(c_tready),
    .out_tdata(c_data), .out_tvalid(c_valid), .out_tready(out_tready),
    .out_sat(c_sat), .sat_clear(sat_clear), .sat_count(c_cnt));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [64:0] p;
    int          acc;
  } beat_t;

  beat_t       pq[$];     // beats inside the pipeline, oldest first
  logic [64:0] src_q[$];  // beats waiting to be offered
  int          cyc = 0;   // number of rising edges so far
  bit          known = 1'b0;
  int          cm = 0, ct = 0, c4 = 0;
  bit          gate = 1'b1;
  bit          auto_clear = 1'b0;
  bit          in_x, out_x, exp_v, exp_rdy;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_val);
    checks++;
    if (act !== exp_val) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", nm, act, exp_val, cyc);
    end
  endtask

  // Reference: value / 2^32, rounded half up or floored, clipped to int32.
  // Returns {sat, data}.
  function automatic logic [32:0] ref_scale(input logic [64:0] p, input bit rnd);
    logic signed [127:0] v;
    v = {{63{p[64]}}, p};
    if (rnd) v = v + (128'sd1 <<< 31);
    v = v >>> 32;
    if (v > 128'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
    if (v < -128'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, v[31:0]};
  endfunction

  function automatic int upd(input int c, input logic clr, input bit inc, input int mx);
    if (clr) return 0;
    if (inc && c < mx) return c + 1;
    return c;
  endfunction

  function automatic bit head_visible();
    return known && pq.size() > 0 && cyc >= pq[0].acc + 2;
  endfunction

  function automatic logic [64:0] rand_prod();
    logic [95:0]        r;
    logic signed [64:0] v;
    logic signed [64:0] m;
    r = {$urandom, $urandom, $urandom};
    case ($urandom_range(0, 3))
      0: v = r[64:0];
      1: v = {{17{r[47]}}, r[47:0]};
      2: begin
        m = {{33{r[31]}}, r[31:0]};
        v = (m <<< 31) + {63'd0, r[33:32]} - 65'sd1;
      end
      default: v = ((r[40] ? -65'sd2147483648 : 65'sd2147483647) <<< 32)
                   + {{32{r[33]}}, r[32:0]};
    endcase
    return v;
  endfunction

  task automatic set_inputs();
    prod_tvalid = gate && (src_q.size() > 0);
    prod_tdata  = (src_q.size() > 0) ? src_q[0] : 65'd0;
    if (auto_clear) sat_clear = head_visible() && out_tready;
  endtask

  // Compare all outputs against the model for the current cycle.
  task automatic eval();
    logic [32:0] rm, rt;
    #1;
    exp_v   = head_visible();
    exp_rdy = (pq.size() < 2) || out_tready;
    if (known) begin
      chk("m_tready", 64'(m_tready), 64'(exp_rdy));
      chk("t_tready", 64'(t_tready), 64'(exp_rdy));
      chk("c_tready", 64'(c_tready), 64'(exp_rdy));
      chk("m_tvalid", 64'(m_valid), 64'(exp_v));
      chk("t_tvalid", 64'(t_valid), 64'(exp_v));
      chk("c_tvalid", 64'(c_valid), 64'(exp_v));
      if (exp_v) begin
        rm = ref_scale(pq[0].p, 1'b1);
        rt = ref_scale(pq[0].p, 1'b0);
        chk("m_data", 64'(m_data), 64'(rm[31:0]));
        chk("m_sat",  64'(m_sat),  64'(rm[32]));
        chk("t_data", 64'(t_data), 64'(rt[31:0]));
        chk("t_sat",  64'(t_sat),  64'(rt[32]));
        chk("c_data", 64'(c_data), 64'(rm[31:0]));
        chk("c_sat",  64'(c_sat),  64'(rm[32]));
      end
      chk("m_cnt", 64'(m_cnt), 64'(cm));
      chk("t_cnt", 64'(t_cnt), 64'(ct));
      chk("c_cnt", 64'(c_cnt), 64'(c4));
    end
    in_x  = known && ap_rst_n && prod_tvalid && exp_rdy;
    out_x = ap_rst_n && exp_v && out_tready;
  endtask

  task automatic advance();
    logic [32:0] rm, rt;
    @(posedge ap_clk);
    if (!ap_rst_n) begin
      pq.delete();
      cm = 0; ct = 0; c4 = 0;
      known = 1'b1;
    end else if (known) begin
      rm = out_x ? ref_scale(pq[0].p, 1'b1) : 33'd0;
      rt = out_x ? ref_scale(pq[0].p, 1'b0) : 33'd0;
      cm = upd(cm, sat_clear, out_x && rm[32], 65535);
      ct = upd(ct, sat_clear, out_x && rt[32], 65535);
      c4 = upd(c4, sat_clear, out_x && rm[32], 15);
      if (out_x) void'(pq.pop_front());
      if (in_x) begin
        pq.push_back('{p: prod_tdata, acc: cyc});
        void'(src_q.pop_front());
      end
    end
    cyc++;
    @(negedge ap_clk);
  endtask

  task automatic step();
    set_inputs();
    eval();
    advance();
  endtask

  task automatic drain(input string nm, input int maxc);
    int n = 0;
    while ((src_q.size() > 0 || pq.size() > 0) && n < maxc) begin
      step();
      n++;
    end
    checks++;
    if (src_q.size() > 0 || pq.size() > 0) begin
      errors++;
      $display("FAIL %s timeout: %0d beats left, want 0", nm, src_q.size() + pq.size());
    end
  endtask

  initial begin
    logic [64:0] p_a, p_b, p_c, p_d, p_e, p_f, p_g;
    p_a = (65'd3 << 32) + (65'd1 << 31);
    p_b = -(65'd1 << 31);
    p_c = -((65'd1 << 31) + 65'd1);
    p_d = -65'd1;
    p_e = (65'd1 << 32) - 65'd1;
    p_f = 65'd1 << 63;
    p_g = -(65'd1 << 63) - (65'd1 << 32);

    @(negedge ap_clk);

    // Pin the reference model with hand-computed values.
    chk("ref_round_up",   64'(ref_scale(p_a, 1'b1)), 64'h0_0000_0004);
    chk("ref_round_zero", 64'(ref_scale(p_b, 1'b1)), 64'h0_0000_0000);
    chk("ref_round_neg",  64'(ref_scale(p_c, 1'b1)), 64'h0_FFFF_FFFF);
    chk("ref_trunc_m1",   64'(ref_scale(p_d, 1'b0)), 64'h0_FFFF_FFFF);
    chk("ref_trunc_frac", 64'(ref_scale(p_e, 1'b0)), 64'h0_0000_0000);
    chk("ref_sat_pos",    64'(ref_scale(p_f, 1'b1)), 64'h1_7FFF_FFFF);
    chk("ref_sat_neg",    64'(ref_scale(p_g, 1'b1)), 64'h1_8000_0000);

    // Reset
    ap_rst_n = 1'b0;
    step();
    step();
    ap_rst_n = 1'b1;
    set_inputs();
    eval();
    chk("rst_tvalid", 64'(m_valid), 64'd0);
    chk("rst_tdata",  64'(m_data), 64'd0);
    chk("rst_cnt",    64'(m_cnt), 64'd0);
    chk("rst_tready", 64'(m_tready), 64'd1);
    advance();

    // Directed rounding / truncation / saturation values
    out_tready = 1'b1;
    gate = 1'b1;
    src_q.push_back(p_a); src_q.push_back(p_b); src_q.push_back(p_c);
    src_q.push_back(p_d); src_q.push_back(p_e);
    src_q.push_back(p_f); src_q.push_back(p_g);
    drain("directed", 50);
    set_inputs();
    eval();
    chk("dir_m_cnt", 64'(m_cnt), 64'd2);
    chk("dir_t_cnt", 64'(t_cnt), 64'd2);
    chk("dir_c_cnt", 64'(c_cnt), 64'd2);
    advance();

    // Backpressure: 10 beats, consumer stalled for cycles 3..7
    for (int i = 0; i < 10; i++) src_q.push_back({{17{1'b0}}, $urandom, 16'h0} - (65'd1 << 47));
    for (int i = 0; i < 40 && (src_q.size() > 0 || pq.size() > 0); i++) begin
      out_tready = !(i >= 3 && i <= 7);
      set_inputs();
      eval();
      if (i == 5) chk("bp_tready_low", 64'(m_tready), 64'd0);
      advance();
    end
    out_tready = 1'b1;
    drain("backpressure", 20);

    // Counter saturation at 15 on the 4-bit counter
    for (int i = 0; i < 17; i++) src_q.push_back(p_f);
    drain("cnt_fill", 60);
    set_inputs();
    eval();
    chk("cnt4_stick", 64'(c_cnt), 64'd15);
    advance();

    // Clear in the same cycle as a saturating handoff
    src_q.push_back(p_f);
    auto_clear = 1'b1;
    drain("cnt_clear", 20);
    auto_clear = 1'b0;
    sat_clear = 1'b0;
    set_inputs();
    eval();
    chk("clr_m_cnt", 64'(m_cnt), 64'd0);
    chk("clr_c_cnt", 64'(c_cnt), 64'd0);
    advance();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (src_q.size() < 3 && $urandom_range(0, 3) != 0) src_q.push_back(rand_prod());
      gate       = ($urandom_range(0, 3) != 0);
      out_tready = ($urandom_range(0, 9) < 7);
      sat_clear  = ($urandom_range(0, 49) == 0);
      step();
    end
    sat_clear = 1'b0;
    gate = 1'b1;
    out_tready = 1'b1;
    drain("random", 50);

    // Reset with two beats in flight
    src_q.push_back(p_f);
    drain("pre_rst", 20);
    src_q.push_back(p_f); src_q.push_back(p_a); src_q.push_back(p_b);
    out_tready = 1'b0;
    step();
    step();
    ap_rst_n = 1'b0;
    step();
    ap_rst_n = 1'b1;
    src_q.delete();
    gate = 1'b0;
    out_tready = 1'b1;
    set_inputs();
    eval();
    chk("mid_rst_tvalid", 64'(m_valid), 64'd0);
    chk("mid_rst_tdata",  64'(m_data), 64'd0);
    chk("mid_rst_cnt",    64'(m_cnt), 64'd0);
    chk("mid_rst_tready", 64'(m_tready), 64'd1);
    advance();
    for (int i = 0; i < 6; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
